// File: rtl/data_check_pkg.sv
// Shared definitions for the data_check receive-side checker and its stream source.
// Contents: LFSR seed and tap positions, the lfsr16_next() step function,
// a 16-bit popcount helper and the checker FSM state encoding.
package data_check_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hABCD;
    localparam int          TAP_A     = 12;
    localparam int          TAP_B     = 3;
    localparam int          TAP_C     = 1;
    localparam int          TAP_D     = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAIL   = 2'd3
    } state_t;

    // Right-shifting XNOR LFSR: feedback enters at bit 15.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
        logic fb;
        fb = ~(v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]);
        return {fb, v[15:1]};
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/data_check_if.sv
// Valid/Data pattern stream between the Data_Gen source (master) and the
// data_check receiver (slave). Valid low means the stream is idle/restarting.
interface data_check_if #(
    parameter int DATA_SIZE = 4
) ();
    logic                 Valid;
    logic [DATA_SIZE-1:0] Data;

    modport master (output Valid, output Data);
    modport slave  (input  Valid, input  Data);
endinterface

// File: rtl/data_check_lfsr16_xnor.sv
// lfsr16_xnor: 16-bit XNOR LFSR with seed load and advance controls.
// Shared by the source and the checker so both generate the same sequence.
// Ports: clk, rstn (async active-low), load (reseed, wins over advance),
//        advance (one step), seed (load value), value (current state).
module lfsr16_xnor
    import data_check_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] value
);
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next-state selection: reseed, step or hold.
    always_comb begin
        if (load) begin
            lfsr_d = seed;
        end else if (advance) begin
            lfsr_d = lfsr16_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;
endmodule

// File: rtl/data_check.sv
// data_check: receive-side checker for the Valid/Data pattern stream.
// Regenerates the expected sequence, acquires lock after LOCK_LEN clean words,
// counts word/bit errors while locked and declares FAIL after LOSS_LEN
// consecutive bad words. Every output is registered (1-cycle latency).
// Ports: clk, rstn (async active-low), s (stream slave: Valid, Data),
//        clr_cnt (sync counter clear), pattern_sel (0=LFSR, 1=counter),
//        locked, fail, err_pulse, err_count, bit_err_count, word_count.
// Optional feature: macro DATA_CHECK_COUNT_MODE_EN adds the counter pattern
// selected by pattern_sel (sampled in IDLE only); undefined -> LFSR only.
module data_check
    import data_check_pkg::*;
#(
    parameter int DATA_SIZE = 4,
    parameter int LOCK_LEN  = 8,
    parameter int LOSS_LEN  = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    data_check_if.slave      s,
    input  logic             clr_cnt,
    input  logic             pattern_sel,
    output logic             locked,
    output logic             fail,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_err_count,
    output logic [CNT_W-1:0] word_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam int RUN_W = $clog2(LOCK_LEN + 1);
    localparam int BAD_W = $clog2(LOSS_LEN + 1);
    localparam int BSW   = CNT_W + 6;

    state_t               state_q, state_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [BAD_W-1:0]     bad_q, bad_d;
    logic                 locked_q, fail_q, err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]     err_count_q, err_count_d;
    logic [CNT_W-1:0]     bit_err_count_q, bit_err_count_d;
    logic [CNT_W-1:0]     word_count_q, word_count_d;
    logic [15:0]          lfsr_s;
    logic [DATA_SIZE-1:0] exp_word_s;
    logic                 match_s;
    logic                 err_inc_s;
    logic [4:0]           pop_s;
    logic [BSW-1:0]       bsum_s;

    lfsr16_xnor u_lfsr (
        .clk     (clk),
        .rstn    (rstn),
        .load    (~s.Valid),
        .advance (s.Valid),
        .seed    (LFSR_SEED),
        .value   (lfsr_s)
    );

`ifdef DATA_CHECK_COUNT_MODE_EN
    logic [DATA_SIZE-1:0] cnt_q, cnt_d;
    logic                 mode_q, mode_d, mode_s;

    // Pattern mode is taken live in IDLE and frozen for the rest of the stream.
    always_comb begin
        mode_s = (state_q == ST_IDLE) ? pattern_sel : mode_q;
        mode_d = mode_s;
        if (!s.Valid) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DATA_SIZE'(1);
        end
        if (mode_s) begin
            exp_word_s = cnt_q;
        end else begin
            exp_word_s = lfsr_s[DATA_SIZE-1:0];
        end
    end

    // Counter-pattern state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end
`else
    logic unused_pattern_sel_s;
    assign unused_pattern_sel_s = pattern_sel;
    assign exp_word_s = lfsr_s[DATA_SIZE-1:0];
`endif

    logic unused_lfsr_s;
    assign unused_lfsr_s = ^lfsr_s;

    assign match_s = (s.Data == exp_word_s);
    assign pop_s   = popcount16(16'(s.Data ^ exp_word_s));
    assign bsum_s  = BSW'(bit_err_count_q) + BSW'(pop_s);

    // Lock FSM: run counts clean words toward lock, bad_run counts errors toward FAIL.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        err_inc_s   = 1'b0;
        if (!s.Valid) begin
            state_d = ST_IDLE;
            run_d   = '0;
            bad_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    run_d   = match_s ? RUN_W'(1) : '0;
                    state_d = (run_d == RUN_W'(LOCK_LEN)) ? ST_LOCKED : ST_ACQ;
                end
                ST_ACQ: begin
                    run_d = match_s ? (run_q + RUN_W'(1)) : '0;
                    if (run_d == RUN_W'(LOCK_LEN)) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_ACQ;
                    end
                end
                ST_LOCKED: begin
                    if (!match_s) begin
                        err_pulse_d = 1'b1;
                        err_inc_s   = 1'b1;
                        bad_d       = bad_q + BAD_W'(1);
                        if (bad_d == BAD_W'(LOSS_LEN)) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Saturating counters; a clear in the same cycle as an increment wins.
    always_comb begin
        if (clr_cnt) begin
            word_count_d = '0;
        end else if (s.Valid && (word_count_q != CNT_MAX)) begin
            word_count_d = word_count_q + CNT_W'(1);
        end else begin
            word_count_d = word_count_q;
        end

        if (clr_cnt) begin
            err_count_d = '0;
        end else if (err_inc_s && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end

        if (clr_cnt) begin
            bit_err_count_d = '0;
        end else if (err_inc_s) begin
            bit_err_count_d = (bsum_s > BSW'(CNT_MAX)) ? CNT_MAX : bsum_s[CNT_W-1:0];
        end else begin
            bit_err_count_d = bit_err_count_q;
        end
    end

    // FSM state, run counters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            run_q           <= '0;
            bad_q           <= '0;
            locked_q        <= 1'b0;
            fail_q          <= 1'b0;
            err_pulse_q     <= 1'b0;
            err_count_q     <= '0;
            bit_err_count_q <= '0;
            word_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            run_q           <= run_d;
            bad_q           <= bad_d;
            locked_q        <= (state_d == ST_LOCKED);
            fail_q          <= (state_d == ST_FAIL);
            err_pulse_q     <= err_pulse_d;
            err_count_q     <= err_count_d;
            bit_err_count_q <= bit_err_count_d;
            word_count_q    <= word_count_d;
        end
    end

    assign locked        = locked_q;
    assign fail          = fail_q;
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_count_q;
    assign bit_err_count = bit_err_count_q;
    assign word_count    = word_count_q;
endmodule

// File: tb/tb_data_check.sv
// Scoreboard bench for data_check: a stream source drives Valid/Data with
// optional corruption, a behavioural checker model predicts every output
// and queues it; a monitor pops and compares after each clock edge.
module tb_data_check;
    localparam int DS    = 4;
    localparam int LOCK  = 8;
    localparam int LOSS  = 4;
    localparam int CNTW  = 4;
    localparam int MAXC  = (1 << CNTW) - 1;
`ifdef DATA_CHECK_COUNT_MODE_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    typedef struct {
        bit locked;
        bit fail;
        bit pulse;
        int ec;
        int bc;
        int wc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            clr_cnt;
    logic            pattern_sel;
    logic            locked, fail, err_pulse;
    logic [CNTW-1:0] err_count, bit_err_count, word_count;

    data_check_if #(.DATA_SIZE(DS)) bus ();

    data_check #(.DATA_SIZE(DS), .LOCK_LEN(LOCK), .LOSS_LEN(LOSS), .CNT_W(CNTW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s             (bus),
        .clr_cnt       (clr_cnt),
        .pattern_sel   (pattern_sel),
        .locked        (locked),
        .fail          (fail),
        .err_pulse     (err_pulse),
        .err_count     (err_count),
        .bit_err_count (bit_err_count),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Checker model state: 0=idle 1=acquiring 2=locked 3=failed.
    int          m_state, m_run, m_bad, m_cnt, m_ec, m_bc, m_wc;
    bit          m_mode, m_pulse;
    logic [15:0] m_lfsr;

    // Source state.
    logic [15:0] src_lfsr;
    int          src_cnt;
    bit          src_mode;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input exp_t e);
        cmp("locked", int'(locked), int'(e.locked));
        cmp("fail", int'(fail), int'(e.fail));
        cmp("err_pulse", int'(err_pulse), int'(e.pulse));
        cmp("err_count", int'(err_count), e.ec);
        cmp("bit_err_count", int'(bit_err_count), e.bc);
        cmp("word_count", int'(word_count), e.wc);
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.locked = 1'b0; e.fail = 1'b0; e.pulse = 1'b0;
        e.ec = 0; e.bc = 0; e.wc = 0;
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0; m_bad = 0; m_cnt = 0;
        m_ec = 0; m_bc = 0; m_wc = 0; m_mode = 1'b0; m_pulse = 1'b0;
        m_lfsr = 16'hABCD;
        src_lfsr = 16'hABCD; src_cnt = 0;
    endtask

    // Behavioural checker: one Valid word (or idle cycle) in, next outputs queued.
    task automatic model_step(input bit v, input logic [DS-1:0] d, input bit clr, input bit psel);
        logic [DS-1:0] ew;
        bit            use_cnt;
        bit            match;
        exp_t          e;
        use_cnt = COUNT_EN && ((m_state == 0) ? psel : m_mode);
        ew      = use_cnt ? DS'(m_cnt) : m_lfsr[DS-1:0];
        m_pulse = 1'b0;
        if (!v) begin
            m_state = 0; m_run = 0; m_bad = 0; m_cnt = 0; m_lfsr = 16'hABCD;
        end else begin
            match = (d == ew);
            m_wc++;
            case (m_state)
                0: begin
                    m_mode  = psel;
                    m_run   = match ? 1 : 0;
                    m_state = (m_run >= LOCK) ? 2 : 1;
                end
                1: begin
                    m_run = match ? m_run + 1 : 0;
                    if (m_run >= LOCK) m_state = 2;
                end
                2: begin
                    if (!match) begin
                        m_pulse = 1'b1;
                        m_ec++;
                        m_bc += $countones(d ^ ew);
                        m_bad++;
                        if (m_bad >= LOSS) m_state = 3;
                    end else begin
                        m_bad = 0;
                    end
                end
                default: ;
            endcase
            m_lfsr = {~(^(m_lfsr & 16'h100B)), m_lfsr[15:1]};
            m_cnt  = (m_cnt + 1) % (1 << DS);
        end
        if (m_ec > MAXC) m_ec = MAXC;
        if (m_bc > MAXC) m_bc = MAXC;
        if (m_wc > MAXC) m_wc = MAXC;
        if (clr) begin m_ec = 0; m_bc = 0; m_wc = 0; end
        e.locked = (m_state == 2);
        e.fail   = (m_state == 3);
        e.pulse  = m_pulse;
        e.ec = m_ec; e.bc = m_bc; e.wc = m_wc;
        exp_q.push_back(e);
    endtask

    // One stream cycle: source word XOR corruption mask, model prediction queued.
    task automatic step(input bit v, input logic [DS-1:0] mask, input bit clr, input bit psel);
        logic [DS-1:0] w;
        @(negedge clk);
        w = src_mode ? DS'(src_cnt) : src_lfsr[DS-1:0];
        bus.Valid   = v;
        bus.Data    = v ? (w ^ mask) : DS'($urandom);
        clr_cnt     = clr;
        pattern_sel = psel;
        model_step(v, bus.Data, clr, psel);
        if (!v) begin
            src_lfsr = 16'hABCD; src_cnt = 0;
        end else begin
            src_lfsr = {~(src_lfsr[12] ^ src_lfsr[3] ^ src_lfsr[1] ^ src_lfsr[0]), src_lfsr[15:1]};
            src_cnt  = (src_cnt + 1) % (1 << DS);
        end
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, 1'b0, src_mode);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 rstn = 1'b0;
        bus.Valid = 1'b0;
        clr_cnt   = 1'b0;
        #1 cmp_all(zero_exp());
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Monitor: compares the queued prediction just after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp_all(e);
            end
        end
    end

    initial begin
        int   len;
        int   prob;
        logic [DS-1:0] m;
        rstn = 1'b0; bus.Valid = 1'b0; bus.Data = '0; clr_cnt = 1'b0; pattern_sel = 1'b0;
        src_mode = 1'b0;
        model_reset();
        #4 cmp_all(zero_exp());
        @(negedge clk);
        rstn = 1'b1;

        // Clean acquisition, then single inverted word while locked.
        step(1'b0, '0, 1'b0, 1'b0);
        clean(10);
        step(1'b1, '1, 1'b0, 1'b0);
        clean(3);
        // Four consecutive corrupted words -> FAIL, then clean restart.
        for (int i = 0; i < LOSS; i++) step(1'b1, DS'(i + 1), 1'b0, 1'b0);
        clean(2);
        step(1'b0, '0, 1'b0, 1'b0);
        clean(9);
        // Mismatch at word 5 of acquisition.
        step(1'b0, '0, 1'b1, 1'b0);
        clean(4);
        step(1'b1, DS'(2), 1'b0, 1'b0);
        clean(9);
        // Saturate error counters, then clear together with an error.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < LOSS - 1; i++) step(1'b1, '1, 1'b0, 1'b0);
            clean(1);
        end
        step(1'b1, '1, 1'b1, 1'b0);
        clean(2);

        // Counter pattern stream with wrap and a mid-stream pattern_sel change.
        if (COUNT_EN) begin
            step(1'b0, '0, 1'b1, 1'b1);
            src_mode = 1'b1;
            clean(12);
            step(1'b1, '0, 1'b0, 1'b0);
            clean(8);
            step(1'b0, '0, 1'b0, 1'b0);
            src_mode = 1'b0;
        end

        // Mid-stream async reset and recovery.
        clean(5);
        do_reset();
        step(1'b0, '0, 1'b0, 1'b0);
        clean(10);

        // Randomized bursts.
        for (int b = 0; b < 40; b++) begin
            step(1'b0, '0, ($urandom_range(0, 3) == 0), 1'b0);
            src_mode = COUNT_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            len  = $urandom_range(1, 30);
            prob = $urandom_range(0, 2);
            for (int i = 0; i < len; i++) begin
                m = '0;
                if ((prob == 1 && $urandom_range(0, 15) == 0) || (prob == 2 && $urandom_range(0, 2) == 0))
                    m = DS'($urandom_range(1, (1 << DS) - 1));
                step(1'b1, m, ($urandom_range(0, 19) == 0),
                     (i == 0) ? src_mode : 1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(negedge clk);
        cmp("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
